// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: state encodings and shared constants for the memory-port arbiter
package mem_arbiter_pkg;
  typedef enum logic [2:0] {ARB_IDLE, ARB_IF, ARB_LD, ARB_ST, ARB_DRAIN} arb_state_e;
  localparam logic TRUE = 1'b1;
  localparam logic FALSE = 1'b0;
  localparam logic [31:0] ZERO = 32'h0;
  localparam logic READ = 1'b0;
  localparam logic WRITE = 1'b1;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory-controller port between instruction fetch and load/store
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_valid_o,
  output logic [31:0] if_inst_o,
  output logic [31:0] if_pc_o,
  input  logic        ls_req,
  input  logic        ls_we,
  input  logic [31:0] ls_addr,
  input  logic [31:0] ls_wdata,
  output logic        ls_done_o,
  output logic [31:0] ls_rdata_o,
  output logic        inst_req,
  output logic [31:0] inst_addr_o,
  output logic        ram_r_req,
  output logic        ram_w_req,
  output logic [31:0] ram_addr_o,
  output logic [31:0] ram_w_data_o,
  input  logic        inst_done_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] inst_pc_i,
  input  logic        ram_done_i,
  input  logic [31:0] ram_r_data_i
);
  arb_state_e state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic [31:0] iaddr_q, iaddr_d, raddr_q, raddr_d, wdata_q, wdata_d;
  logic [31:0] if_inst_q, if_inst_d, if_pc_q, if_pc_d, ls_rdata_q, ls_rdata_d;
  logic if_valid_q, if_valid_d, ls_done_q, ls_done_d;
  logic fetch_ok, starved, grant_if, grant_ls, in_ram;
  always_comb begin
    fetch_ok = if_req && !flush;
    starved = starve_q == CNT_W'(STARVE_LIMIT);
    grant_if = state_q == ARB_IDLE && fetch_ok && (starved || !ls_req);
    grant_ls = state_q == ARB_IDLE && ls_req && !grant_if;
    in_ram = state_q == ARB_LD || state_q == ARB_ST;
    state_d = state_q;
    case (state_q)
      ARB_IDLE:       state_d = grant_if ? ARB_IF : !grant_ls ? ARB_IDLE : ls_we == WRITE ? ARB_ST : ARB_LD;
      ARB_IF:         state_d = inst_done_i ? ARB_IDLE : flush ? ARB_DRAIN : ARB_IF;
      ARB_DRAIN:      state_d = inst_done_i ? ARB_IDLE : ARB_DRAIN;
      ARB_LD, ARB_ST: state_d = ram_done_i ? ARB_IDLE : state_q;
      default:        state_d = ARB_IDLE;
    endcase
    iaddr_d = grant_if ? if_addr : iaddr_q;
    raddr_d = grant_ls ? ls_addr : raddr_q;
    wdata_d = grant_ls ? ls_wdata : wdata_q;
    // a flush landing on the done cycle still discards the fetched word
    if_valid_d = state_q == ARB_IF && inst_done_i && !flush;
    if_inst_d = if_valid_d ? inst_i : if_inst_q;
    if_pc_d = if_valid_d ? inst_pc_i : if_pc_q;
    ls_done_d = in_ram && ram_done_i;
    ls_rdata_d = state_q == ARB_LD && ram_done_i ? ram_r_data_i : ls_rdata_q;
    starve_d = flush || grant_if ? '0 : grant_ls && if_req && !starved ? starve_q + 1'b1 : starve_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      starve_q <= '0;
      iaddr_q <= ZERO;
      raddr_q <= ZERO;
      wdata_q <= ZERO;
      if_inst_q <= ZERO;
      if_pc_q <= ZERO;
      ls_rdata_q <= ZERO;
      if_valid_q <= FALSE;
      ls_done_q <= FALSE;
    end else begin
      state_q <= state_d;
      starve_q <= starve_d;
      iaddr_q <= iaddr_d;
      raddr_q <= raddr_d;
      wdata_q <= wdata_d;
      if_inst_q <= if_inst_d;
      if_pc_q <= if_pc_d;
      ls_rdata_q <= ls_rdata_d;
      if_valid_q <= if_valid_d;
      ls_done_q <= ls_done_d;
    end
  end
  // request lines drop on the done cycle so the controller never sees a second request
  assign inst_req = (state_q == ARB_IF || state_q == ARB_DRAIN) && !inst_done_i;
  assign ram_r_req = state_q == ARB_LD && !ram_done_i;
  assign ram_w_req = state_q == ARB_ST && !ram_done_i;
  assign inst_addr_o = iaddr_q;
  assign ram_addr_o = raddr_q;
  assign ram_w_data_o = wdata_q;
  assign if_valid_o = if_valid_q;
  assign if_inst_o = if_inst_q;
  assign if_pc_o = if_pc_q;
  assign ls_done_o = ls_done_q;
  assign ls_rdata_o = ls_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vector table, starvation sequence and randomized model check
module tb_mem_arbiter;
  localparam int LIMIT = 4;
  logic clk = 1'b0;
  logic rst, flush, if_req, ls_req, ls_we, inst_done_i, ram_done_i;
  logic [31:0] if_addr, ls_addr, ls_wdata, inst_i, inst_pc_i, ram_r_data_i;
  logic if_valid_o, ls_done_o, inst_req, ram_r_req, ram_w_req;
  logic [31:0] if_inst_o, if_pc_o, ls_rdata_o, inst_addr_o, ram_addr_o, ram_w_data_o;
  int total = 0, bad = 0;

  mem_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_req(if_req), .if_addr(if_addr), .if_valid_o(if_valid_o), .if_inst_o(if_inst_o), .if_pc_o(if_pc_o),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_done_o(ls_done_o), .ls_rdata_o(ls_rdata_o),
    .inst_req(inst_req), .inst_addr_o(inst_addr_o), .ram_r_req(ram_r_req), .ram_w_req(ram_w_req),
    .ram_addr_o(ram_addr_o), .ram_w_data_o(ram_w_data_o),
    .inst_done_i(inst_done_i), .inst_i(inst_i), .inst_pc_i(inst_pc_i),
    .ram_done_i(ram_done_i), .ram_r_data_i(ram_r_data_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " if_valid"}, 32'(if_valid_o), 0);
    chk({nm, " if_inst"}, if_inst_o, 0);
    chk({nm, " if_pc"}, if_pc_o, 0);
    chk({nm, " ls_done"}, 32'(ls_done_o), 0);
    chk({nm, " ls_rdata"}, ls_rdata_o, 0);
    chk({nm, " reqs"}, {29'b0, inst_req, ram_r_req, ram_w_req}, 0);
    chk({nm, " addrs"}, inst_addr_o | ram_addr_o | ram_w_data_o, 0);
  endtask

  task automatic clear_in;
    flush = 0; if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_addr = 0; ls_wdata = 0;
    inst_done_i = 0; inst_i = 0; inst_pc_i = 0; ram_done_i = 0; ram_r_data_i = 0;
  endtask

  typedef struct {
    logic fl, ir; logic [31:0] ia;
    logic lr, lw; logic [31:0] la, wd;
    logic idn; logic [31:0] iin, ipc;
    logic rdn; logic [31:0] rd;
    logic e_ireq, e_rr, e_wr, e_ifv, e_lsd; logic [31:0] e_pc, e_inst, e_rdata;
  } vec_t;
  vec_t tv[$];

  localparam logic [31:0] I0 = 32'h00A00093, I1 = 32'h11111111, I2 = 32'h22222222, DB = 32'hDEADBEEF;

  // reference model state: owner 0 idle, 1 fetch, 2 load, 3 store, 4 discarded fetch
  int own, cnt, ilat, rlat;
  bit ibusy, rbusy, fl_prev, fo;
  logic m_ifv, m_lsd;
  logic [31:0] m_iaddr, m_raddr, m_wdata, m_inst, m_pc, m_rdata;

  initial begin
    clear_in();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 0;
    // reset in the middle of a load
    ls_req = 1; ls_we = 0; ls_addr = 32'h2000; ls_wdata = 32'h99;
    @(posedge clk); #1;
    chk("ld grant r_req", 32'(ram_r_req), 1);
    chk("ld grant addr", ram_addr_o, 32'h2000);
    rst = 1; ram_done_i = 1; ram_r_data_i = 32'h4444;
    @(posedge clk); #1;
    ram_done_i = 0;
    chk_zero("rst mid ld 1");
    @(posedge clk); #1;
    rst = 0; ls_req = 0;
    chk_zero("rst mid ld 2");
    @(posedge clk); #1;
    chk_zero("after rst");

    // fl ir ia lr lw la wd idn iin ipc rdn rd | ireq rr wr ifv lsd pc inst rdata
    tv.push_back('{0,1,32'h10, 0,0,0,0, 0,0,0, 0,0,         0,0,0,0,0, 0,0,0});
    tv.push_back('{0,1,32'h10, 0,0,0,0, 0,0,0, 1,32'h5555,  1,0,0,0,0, 0,0,0});
    tv.push_back('{0,1,32'h10, 0,0,0,0, 1,I0,32'h10, 0,0,   0,0,0,0,0, 0,0,0});
    tv.push_back('{0,0,0,      0,0,0,0, 0,0,0, 0,0,         0,0,0,1,0, 32'h10,I0,0});
    tv.push_back('{0,0,0,      0,0,0,0, 0,0,0, 0,0,         0,0,0,0,0, 32'h10,I0,0});
    tv.push_back('{0,1,32'h40, 1,0,32'h1000,0, 0,0,0, 0,0,  0,0,0,0,0, 32'h10,I0,0});
    tv.push_back('{0,1,32'h40, 1,0,32'h1000,0, 0,0,0, 0,0,  0,1,0,0,0, 32'h10,I0,0});
    tv.push_back('{0,1,32'h40, 1,0,32'h1000,0, 0,0,0, 1,DB, 0,0,0,0,0, 32'h10,I0,0});
    tv.push_back('{0,1,32'h40, 0,0,0,0, 0,0,0, 0,0,         0,0,0,0,1, 32'h10,I0,DB});
    tv.push_back('{0,1,32'h40, 0,0,0,0, 0,0,0, 0,0,         1,0,0,0,0, 32'h10,I0,DB});
    tv.push_back('{0,1,32'h40, 0,0,0,0, 1,I1,32'h40, 0,0,   0,0,0,0,0, 32'h10,I0,DB});
    tv.push_back('{0,0,0,      0,0,0,0, 0,0,0, 0,0,         0,0,0,1,0, 32'h40,I1,DB});
    tv.push_back('{0,1,32'h20, 0,0,0,0, 0,0,0, 0,0,         0,0,0,0,0, 32'h40,I1,DB});
    tv.push_back('{0,1,32'h20, 0,0,0,0, 0,0,0, 0,0,         1,0,0,0,0, 32'h40,I1,DB});
    tv.push_back('{1,1,32'h20, 0,0,0,0, 0,0,0, 0,0,         1,0,0,0,0, 32'h40,I1,DB});
    tv.push_back('{0,0,0,      0,0,0,0, 0,0,0, 0,0,         1,0,0,0,0, 32'h40,I1,DB});
    tv.push_back('{0,0,0,      0,0,0,0, 1,32'hBAD,32'h20, 0,0, 0,0,0,0,0, 32'h40,I1,DB});
    tv.push_back('{0,1,32'h80, 0,0,0,0, 0,0,0, 0,0,         0,0,0,0,0, 32'h40,I1,DB});
    tv.push_back('{0,1,32'h80, 0,0,0,0, 0,0,0, 0,0,         1,0,0,0,0, 32'h40,I1,DB});
    tv.push_back('{0,1,32'h80, 0,0,0,0, 1,I2,32'h80, 0,0,   0,0,0,0,0, 32'h40,I1,DB});
    tv.push_back('{0,0,0,      0,0,0,0, 0,0,0, 0,0,         0,0,0,1,0, 32'h80,I2,DB});
    tv.push_back('{0,1,32'h30, 0,0,0,0, 0,0,0, 0,0,         0,0,0,0,0, 32'h80,I2,DB});
    tv.push_back('{0,1,32'h30, 0,0,0,0, 0,0,0, 0,0,         1,0,0,0,0, 32'h80,I2,DB});
    tv.push_back('{1,1,32'h30, 0,0,0,0, 1,32'h33333333,32'h30, 0,0, 0,0,0,0,0, 32'h80,I2,DB});
    tv.push_back('{0,0,0,      0,0,0,0, 0,0,0, 0,0,         0,0,0,0,0, 32'h80,I2,DB});
    tv.push_back('{0,0,0,      1,1,32'h3000,32'hCAFEF00D, 0,0,0, 0,0, 0,0,0,0,0, 32'h80,I2,DB});
    tv.push_back('{1,0,0,      1,1,32'h3000,32'hCAFEF00D, 0,0,0, 0,0, 0,0,1,0,0, 32'h80,I2,DB});
    tv.push_back('{0,0,0,      1,1,32'h3000,32'hCAFEF00D, 0,0,0, 0,0, 0,0,1,0,0, 32'h80,I2,DB});
    tv.push_back('{0,0,0,      1,1,32'h3000,32'hCAFEF00D, 0,0,0, 1,32'h7777, 0,0,0,0,0, 32'h80,I2,DB});
    tv.push_back('{0,0,0,      0,0,0,0, 0,0,0, 0,0,         0,0,0,0,1, 32'h80,I2,DB});

    for (int i = 0; i < tv.size(); i++) begin
      flush = tv[i].fl; if_req = tv[i].ir; if_addr = tv[i].ia;
      ls_req = tv[i].lr; ls_we = tv[i].lw; ls_addr = tv[i].la; ls_wdata = tv[i].wd;
      inst_done_i = tv[i].idn; inst_i = tv[i].iin; inst_pc_i = tv[i].ipc;
      ram_done_i = tv[i].rdn; ram_r_data_i = tv[i].rd;
      #1;
      chk($sformatf("row%0d reqs", i), {29'b0, inst_req, ram_r_req, ram_w_req}, {29'b0, tv[i].e_ireq, tv[i].e_rr, tv[i].e_wr});
      chk($sformatf("row%0d pulses", i), {30'b0, if_valid_o, ls_done_o}, {30'b0, tv[i].e_ifv, tv[i].e_lsd});
      chk($sformatf("row%0d if_pc", i), if_pc_o, tv[i].e_pc);
      chk($sformatf("row%0d if_inst", i), if_inst_o, tv[i].e_inst);
      chk($sformatf("row%0d ls_rdata", i), ls_rdata_o, tv[i].e_rdata);
      if (tv[i].e_wr) chk($sformatf("row%0d w_data", i), ram_w_data_o, 32'hCAFEF00D);
      @(posedge clk); #1;
    end

    // starvation: fetch and alternating load/store held continuously
    clear_in();
    if_req = 1; if_addr = 32'h100; ls_req = 1; ls_addr = 32'h4000; ls_wdata = 32'h55;
    for (int g = 0; g < 10; g++) begin
      int w, got, exp_k;
      w = 0;
      while (!(inst_req || ram_r_req || ram_w_req) && w < 20) begin
        @(posedge clk); #1; w++;
      end
      got = inst_req ? 1 : ram_w_req ? 2 : ram_r_req ? 3 : 0;
      exp_k = (g % 5 == 4) ? 1 : (ls_we ? 2 : 3);
      chk($sformatf("starve grant%0d kind", g), 32'(got), 32'(exp_k));
      if (inst_req) begin inst_done_i = 1; inst_i = 32'(g); inst_pc_i = if_addr; end
      else begin ram_done_i = 1; ram_r_data_i = 32'(g); end
      @(posedge clk); #1;
      inst_done_i = 0; ram_done_i = 0;
      if (got == 1) begin
        chk($sformatf("starve grant%0d if_valid", g), 32'(if_valid_o), 1);
        if_addr = if_addr + 4;
      end else begin
        chk($sformatf("starve grant%0d ls_done", g), 32'(ls_done_o), 1);
        ls_we = ~ls_we;
      end
    end

    // randomized run against the reference model
    clear_in();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    own = 0; cnt = 0; ibusy = 0; rbusy = 0; fl_prev = 0; m_ifv = 0; m_lsd = 0;
    m_iaddr = 0; m_raddr = 0; m_wdata = 0; m_inst = 0; m_pc = 0; m_rdata = 0;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd if_valid", 32'(if_valid_o), 32'(m_ifv));
      chk("rnd if_inst", if_inst_o, m_inst);
      chk("rnd if_pc", if_pc_o, m_pc);
      chk("rnd ls_done", 32'(ls_done_o), 32'(m_lsd));
      chk("rnd ls_rdata", ls_rdata_o, m_rdata);
      chk("rnd inst_addr", inst_addr_o, m_iaddr);
      chk("rnd ram_addr", ram_addr_o, m_raddr);
      chk("rnd w_data", ram_w_data_o, m_wdata);
      if (if_req && (if_valid_o || fl_prev)) if_req = 0;
      else if (!if_req && $urandom_range(0, 1) == 1) begin if_req = 1; if_addr = $urandom & 32'hFFFF_FFFC; end
      if (ls_req && ls_done_o) ls_req = 0;
      else if (!ls_req && $urandom_range(0, 2) == 0) begin
        ls_req = 1; ls_we = 1'($urandom_range(0, 1)); ls_addr = $urandom; ls_wdata = $urandom;
      end
      flush = $urandom_range(0, 9) == 0;
      inst_done_i = 0; ram_done_i = 0;
      if (ibusy) begin ilat--; if (ilat == 0) begin inst_done_i = 1; ibusy = 0; end end
      if (rbusy) begin rlat--; if (rlat == 0) begin ram_done_i = 1; rbusy = 0; end end
      if (!ibusy && $urandom_range(0, 29) == 0) inst_done_i = 1;
      if (!rbusy && $urandom_range(0, 29) == 0) ram_done_i = 1;
      inst_i = $urandom; inst_pc_i = inst_addr_o; ram_r_data_i = $urandom;
      #1;
      chk("rnd inst_req", 32'(inst_req), 32'((own == 1 || own == 4) && !inst_done_i));
      chk("rnd ram_r_req", 32'(ram_r_req), 32'(own == 2 && !ram_done_i));
      chk("rnd ram_w_req", 32'(ram_w_req), 32'(own == 3 && !ram_done_i));
      chk("rnd one pulse", 32'(if_valid_o && ls_done_o), 0);
      if (inst_req && !ibusy) begin ibusy = 1; ilat = $urandom_range(1, 3); end
      if ((ram_r_req || ram_w_req) && !rbusy) begin rbusy = 1; rlat = $urandom_range(1, 3); end
      fo = if_req && !flush;
      m_ifv = 0; m_lsd = 0;
      case (own)
        0: if (fo && (cnt == LIMIT || !ls_req)) begin own = 1; m_iaddr = if_addr; cnt = 0; end
           else if (ls_req) begin
             own = ls_we ? 3 : 2; m_raddr = ls_addr; m_wdata = ls_wdata;
             if (fo && cnt < LIMIT) cnt++;
           end
        1: if (inst_done_i) begin
             own = 0;
             if (!flush) begin m_ifv = 1; m_inst = inst_i; m_pc = inst_pc_i; end
           end else if (flush) own = 4;
        4: if (inst_done_i) own = 0;
        2: if (ram_done_i) begin own = 0; m_lsd = 1; m_rdata = ram_r_data_i; end
        3: if (ram_done_i) begin own = 0; m_lsd = 1; end
        default: own = 0;
      endcase
      if (flush) cnt = 0;
      fl_prev = flush;
      @(posedge clk); #1;
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
